regfile_wb: RTL
===============

# regfile_wb

Integer register file that terminates the write-back path: it accepts the single selected write-back value (PC+4, ALU result or load data) and commits it to the architectural registers. It also serves two combinational read ports to decode. A per-register pending scoreboard tracks outstanding multi-cycle loads and raises a stall when decode reads a register whose value has not yet been written back. It sits between the write-back selector and the decode/operand stage of the CPU.

## Interface

Parameters:

- DATA_WIDTH, 32, register width in bits.
- REG_ADDR_WIDTH, 5, register index width; the file holds 2**REG_ADDR_WIDTH registers.

Ports:

- clk_i  input  1  system clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- rs1_ren_i  input  1  decode actually uses rs1 this cycle.
- rs1_addr_i  input  REG_ADDR_WIDTH  read port 1 index.
- rs1_data_o  output  DATA_WIDTH  read port 1 data (combinational).
- rs2_ren_i  input  1  decode actually uses rs2 this cycle.
- rs2_addr_i  input  REG_ADDR_WIDTH  read port 2 index.
- rs2_data_o  output  DATA_WIDTH  read port 2 data (combinational).
- wb_en_i  input  1  commit wb_data_i to wb_addr_i this cycle.
- wb_addr_i  input  REG_ADDR_WIDTH  write-back destination index.
- wb_data_i  input  DATA_WIDTH  write-back value from the selector.
- busy_set_i  input  1  a load targeting busy_addr_i issues this cycle.
- busy_addr_i  input  REG_ADDR_WIDTH  destination of the issuing load.
- stall_o  output  1  decode must hold; a used source is pending.
- pending_o  output  2**REG_ADDR_WIDTH  scoreboard bit vector (debug/verification).

## Operation

- Storage: registers 1..N-1 are flops. Register 0 reads as 0 always; writes to index 0 are discarded.
- Write: on a rising edge with wb_en_i=1 and wb_addr_i≠0, reg[wb_addr_i] ← wb_data_i.
- Read, per port: index 0 → 0. Otherwise, if wb_en_i=1 and wb_addr_i equals the read index → wb_data_i (write-first bypass). Otherwise → reg[index].
- Scoreboard pending[i], i≥1:
  - Set on an edge with busy_set_i=1 and busy_addr_i=i.
  - Cleared on an edge with wb_en_i=1 and wb_addr_i=i.
  - Set and clear on the same index in the same cycle: set wins (a new load issued behind the completing one).
  - busy_set_i to index 0 is ignored. pending[0] is always 0.
- Stall: stall_o = hazard1 | hazard2.
  - hazard1 = rs1_ren_i & pending[rs1_addr_i] & ~(wb_en_i & wb_addr_i==rs1_addr_i); hazard2 is the same for rs2.
  - A register being written back this cycle does not stall, because the bypass supplies its value.
  - ren=0 never stalls.
- stall_o does not gate busy_set_i or wb_en_i. The pipeline controller must not assert busy_set_i for an instruction it is stalling.
- Reset: all registers ← 0 and all pending bits ← 0. Reset overrides any simultaneous wb_en_i or busy_set_i.

## Timing

- Write latency 1: the value is visible from reg[] on the cycle after the commit edge, and on the bypass in the commit cycle itself.
- Scoreboard latency 1: pending_o and stall_o reflect a busy_set_i from the next cycle onward. A read of busy_addr_i in the issue cycle itself does not stall.
- rs*_data_o and stall_o are combinational from the addresses, ren, wb_* and current state. There is no registered output path.
- Outputs after reset: pending_o=0. rs*_data_o=0 for any address with no write in progress. stall_o=0.
- Arbitrary length between busy_set_i and the matching write-back. Multiple distinct registers may be pending at once. Re-setting an already-pending register keeps it pending.
- Reset asserted mid-load clears pending. A later write-back for that load still writes the register if wb_en_i=1; correctness of that write-back is the controller's concern.

## Test plan

- Reset then read every index on both ports → all 0. pending_o=0, stall_o=0.
- Write x5=0xDEADBEEF with rs1_addr_i=5 in the same cycle → rs1_data_o=0xDEADBEEF (bypass). Next cycle with wb_en_i=0 → still 0xDEADBEEF. Write x0=0x1234 → reading x0 gives 0, pending[0]=0.
- busy_set x7. Next cycle rs2_ren_i=1, rs2_addr_i=7 → stall_o=1 for 3 cycles. Write-back x7=0x55 → same cycle stall_o=0, rs2_data_o=0x55. Next cycle pending[7]=0.
- busy_set x3 and wb x3=0xAA in the same cycle with x3 previously pending → next cycle pending[3]=1, reg x3=0xAA, read of x3 with ren=1 stalls.
- pending x9 with rs1_addr_i=9, rs1_ren_i=0 → stall_o=0. Pending x4 and x6, read rs1=4, rs2=6, write-back x4 only → stall_o=1 (hazard2). Write-back x6 → stall_o=0.
- busy_set x2 and write x8=0x77, then rst_i=1 for one cycle → pending_o=0 and x8 reads 0. A write-back during the reset cycle is discarded.

Source files
------------

// File: rtl/regfile_wb.sv
// regfile_wb: write-back register file; ports: clk_i/rst_i, two comb read ports (rs*_ren_i/addr_i/data_o), write-back (wb_en_i/addr_i/data_i), load scoreboard (busy_set_i/busy_addr_i), stall_o, pending_o
module regfile_wb #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          rs1_ren_i,
  input  logic [REG_ADDR_WIDTH-1:0]     rs1_addr_i,
  output logic [DATA_WIDTH-1:0]         rs1_data_o,
  input  logic                          rs2_ren_i,
  input  logic [REG_ADDR_WIDTH-1:0]     rs2_addr_i,
  output logic [DATA_WIDTH-1:0]         rs2_data_o,
  input  logic                          wb_en_i,
  input  logic [REG_ADDR_WIDTH-1:0]     wb_addr_i,
  input  logic [DATA_WIDTH-1:0]         wb_data_i,
  input  logic                          busy_set_i,
  input  logic [REG_ADDR_WIDTH-1:0]     busy_addr_i,
  output logic                          stall_o,
  output logic [2**REG_ADDR_WIDTH-1:0]  pending_o
);
  localparam int N = 2**REG_ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] regs [N];
  logic [N-1:0] pend, set_v, clr_v;
  logic hit1, hit2;
  assign set_v = N'(busy_set_i) << busy_addr_i;
  assign clr_v = N'(wb_en_i) << wb_addr_i;
  assign hit1 = wb_en_i && wb_addr_i == rs1_addr_i;
  assign hit2 = wb_en_i && wb_addr_i == rs2_addr_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend <= '0;
      for (int i = 0; i < N; i++) regs[i] <= '0;
    end else begin
      pend <= ((pend & ~clr_v) | set_v) & {{(N-1){1'b1}}, 1'b0};
      if (wb_en_i && wb_addr_i != '0) regs[wb_addr_i] <= wb_data_i;
    end
  end
  always_comb begin
    rs1_data_o = rs1_addr_i == '0 ? '0 : hit1 ? wb_data_i : regs[rs1_addr_i];
    rs2_data_o = rs2_addr_i == '0 ? '0 : hit2 ? wb_data_i : regs[rs2_addr_i];
    stall_o    = (rs1_ren_i && pend[rs1_addr_i] && !hit1) || (rs2_ren_i && pend[rs2_addr_i] && !hit2);
  end
  assign pending_o = pend;
endmodule
